// File: rtl/alu_issue_unit.sv
// Issue unit for the combinational ALU: accepts one operation at a time, holds the
// operands stable for a programmable settle time, then captures and returns the result.
module alu_issue_unit #(
   parameter int SETTLE = 1,
   parameter int WIDTH  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_op,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_zero,
   input  logic             alu_ovfl,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_r,
   output logic             rsp_zero,
   output logic             rsp_ovfl,
   output logic             ovfl_sticky,
   input  logic             ovfl_clr
);

   if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("alu_issue_unit: SETTLE must be in 1..15");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [3:0]       cnt_r;
   logic [WIDTH-1:0] opa_r;
   logic [WIDTH-1:0] opb_r;
   logic             op_r;
   logic             accept_s;
   logic             capture_s;

   assign alu_a  = opa_r;
   assign alu_b  = opb_r;
   assign alu_op = op_r;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode and the accept/capture strobes.
   always_comb begin
      state_s   = state_r;
      accept_s  = 1'b0;
      capture_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (req_valid) begin
               accept_s = 1'b1;
               state_s  = S_SETTLE;
            end else begin
               state_s  = S_IDLE;
            end
         end
         S_SETTLE: begin
            if (cnt_r == 4'd0) begin
               capture_s = 1'b1;
               state_s   = S_HOLD;
            end else begin
               state_s   = S_SETTLE;
            end
         end
         S_HOLD: begin
            if (rsp_ready) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_HOLD;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Operand registers and settle counter; counter starts at SETTLE so the capture
   // edge lands SETTLE+1 edges after acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa_r <= {WIDTH{1'b0}};
         opb_r <= {WIDTH{1'b0}};
         op_r  <= 1'b0;
         cnt_r <= 4'd0;
      end else if (accept_s) begin
         opa_r <= req_a;
         opb_r <= req_b;
         op_r  <= req_op;
         cnt_r <= 4'(SETTLE);
      end else if (state_r == S_SETTLE && cnt_r != 4'd0) begin
         cnt_r <= cnt_r - 4'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Result capture, registered handshake outputs and sticky overflow (set beats clear).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_r       <= {WIDTH{1'b0}};
         rsp_zero    <= 1'b0;
         rsp_ovfl    <= 1'b0;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         ovfl_sticky <= 1'b0;
      end else begin
         if (capture_s) begin
            rsp_r    <= alu_r;
            rsp_zero <= alu_zero;
            rsp_ovfl <= alu_ovfl;
         end
         req_ready <= (state_s == S_IDLE);
         rsp_valid <= (state_s == S_HOLD);
         if (capture_s && alu_ovfl) begin
            ovfl_sticky <= 1'b1;
         end else if (ovfl_clr) begin
            ovfl_sticky <= 1'b0;
         end
      end
   end

endmodule
